// File: rtl/sprite_shadow_pkg.sv
// Shared types and constants for the sprite attribute shadow copier.
package sprite_shadow_pkg;

    localparam int unsigned NENT   = 128;
    localparam int unsigned NBANK  = 3;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned ENT_AW = 7;
    localparam int unsigned SRC_AW = 9;
    localparam int unsigned WORD_W = NBANK * LANE_W;

    // Final source address of a copy: bank 2, index 127.
    localparam logic [SRC_AW-1:0] LAST_CNT = 9'h17F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FIN  = 2'd3
    } state_t;

    // One-hot byte enable for a source bank; bank 3 maps to no lane at all.
    function automatic logic [NBANK-1:0] lane_be(input logic [1:0] lane);
        return NBANK'(1) << lane;
    endfunction

endpackage

// File: rtl/sprite_shadow_dpram.sv
// Shadow attribute RAM: one write port with per-byte enables, one registered
// read port. Reads return the pre-write contents on a same-entry collision.
module sprite_shadow_dpram
    import sprite_shadow_pkg::*;
#(
    parameter int unsigned AW = ENT_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [NBANK-1:0]  be,
    input  logic [AW-1:0]     wr_addr,
    input  logic [LANE_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [WORD_W-1:0] rd_data_d;
    logic [WORD_W-1:0] rd_data_q;

    // Each byte lane is its own array so lanes can be written independently.
    for (genvar b = 0; b < NBANK; b++) begin : g_lane
        logic [LANE_W-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we && be[b]) begin
                mem[wr_addr] <= wr_data;
            end
        end

        assign rd_data_d[b*LANE_W +: LANE_W] = mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sprite_attr_shadow.sv
// Copies the three CPU sprite byte banks into the renderer's shadow attribute
// table at each vertical-blank start. Define SPRITE_SHADOW_DBUF_EN for a
// double-buffered table that swaps pages only when a copy completes.
module sprite_attr_shadow
    import sprite_shadow_pkg::*;
(
    input  logic              VCLKx4,
    input  logic              RESET,
    input  logic              VBLK,
    input  logic              COPY_EN,
    output logic [SRC_AW-1:0] SRC_A,
    output logic              SRC_RD,
    input  logic              SRC_ACK,
    input  logic [LANE_W-1:0] SRC_D,
    input  logic [ENT_AW-1:0] SPRA_A,
    output logic [WORD_W-1:0] SPRA_D,
    output logic              BUSY,
    output logic              DONE,
    output logic              OVERRUN
);

`ifdef SPRITE_SHADOW_DBUF_EN
    localparam int unsigned RAM_AW = ENT_AW + 1;
`else
    localparam int unsigned RAM_AW = ENT_AW;
`endif

    state_t              state_q, state_d;
    logic [SRC_AW-1:0]   cnt_q, cnt_d;
    logic                src_rd_q, src_rd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic                vblk_q, vblk_d;

    logic                rise_c;
    logic                wr_en_c;
    logic [NBANK-1:0]    wr_be_c;
    logic [RAM_AW-1:0]   wr_addr_c;
    logic [RAM_AW-1:0]   rd_addr_c;

    assign rise_c  = VBLK & ~vblk_q;
    assign wr_be_c = lane_be(cnt_q[SRC_AW-1 -: 2]);

    // Copy sequencer: one request per source byte, bank-major order.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        src_rd_d  = src_rd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        overrun_d = overrun_q | (rise_c & busy_q);
        vblk_d    = VBLK;
        wr_en_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise_c && COPY_EN) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            REQ: begin
                src_rd_d = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (SRC_ACK) begin
                    wr_en_c  = 1'b1;
                    src_rd_d = 1'b0;
                    if (cnt_q == LAST_CNT) begin
                        state_d = FIN;
                    end else begin
                        cnt_d   = cnt_q + SRC_AW'(1);
                        state_d = REQ;
                    end
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge VCLKx4 or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            src_rd_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            vblk_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            src_rd_q  <= src_rd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            vblk_q    <= vblk_d;
        end
    end

`ifdef SPRITE_SHADOW_DBUF_EN
    logic page_q, page_d;

    // Front page flips on the DONE cycle only, so an aborted copy never shows.
    always_comb begin
        page_d = page_q ^ (state_q == FIN);
    end

    // Kept across RESET, like the RAM it selects, so the displayed page survives an abort.
    always_ff @(posedge VCLKx4) begin
        page_q <= page_d;
    end

    assign wr_addr_c = {~page_q, cnt_q[ENT_AW-1:0]};
    assign rd_addr_c = {page_q, SPRA_A};
`else
    assign wr_addr_c = cnt_q[ENT_AW-1:0];
    assign rd_addr_c = SPRA_A;
`endif

    sprite_shadow_dpram #(
        .AW (RAM_AW)
    ) u_ram (
        .clk     (VCLKx4),
        .rst     (RESET),
        .we      (wr_en_c),
        .be      (wr_be_c),
        .wr_addr (wr_addr_c),
        .wr_data (SRC_D),
        .rd_addr (rd_addr_c),
        .rd_data (SPRA_D)
    );

    assign SRC_A   = cnt_q;
    assign SRC_RD  = src_rd_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_sprite_attr_shadow.sv
// Directed bench for sprite_attr_shadow; covers both the single-page build and
// the SPRITE_SHADOW_DBUF_EN build.
module tb_sprite_attr_shadow;

    logic        clk = 1'b0;
    logic        rst;
    logic        vblk;
    logic        copy_en;
    logic [8:0]  src_a;
    logic        src_rd;
    logic        src_ack;
    logic [7:0]  src_d;
    logic [6:0]  spra_a;
    logic [23:0] spra_d;
    logic        busy;
    logic        done;
    logic        overrun;

    logic [7:0]  src_mem [512];
    logic [23:0] model_tab [128];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ack_cnt = 0;
    bit          spur_on = 1'b0;

    always #5 clk = ~clk;

    sprite_attr_shadow dut (
        .VCLKx4  (clk),
        .RESET   (rst),
        .VBLK    (vblk),
        .COPY_EN (copy_en),
        .SRC_A   (src_a),
        .SRC_RD  (src_rd),
        .SRC_ACK (src_ack),
        .SRC_D   (src_d),
        .SPRA_A  (spra_a),
        .SPRA_D  (spra_d),
        .BUSY    (busy),
        .DONE    (done),
        .OVERRUN (overrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Source byte for bank b, index i; sel 1 is the alternate frame.
    function automatic logic [7:0] pat(input int sel, input int b, input int i);
        logic [7:0] v;
        v = 8'((b << 6) ^ i);
        return (sel == 1) ? (v ^ 8'h3C) : v;
    endfunction

    task automatic fill_src(input int sel);
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 128; i++)
                src_mem[b*128 + i] = pat(sel, b, i);
    endtask

    // Apply the first n source bytes of a copy, in copy order, to the model.
    task automatic model_copy(input int sel, input int n);
        for (int k = 0; k < n; k++) begin
            model_tab[k % 128][(k / 128)*8 +: 8] = pat(sel, k / 128, k % 128);
        end
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 128; i++) begin
            spra_a = 7'(i);
            @(negedge clk);
            check_eq($sformatf("%s[%0d]", tag, i), 32'(spra_d), 32'(model_tab[i]));
        end
    endtask

    task automatic pulse_vblk(input logic en);
        @(negedge clk);
        copy_en = en;
        vblk    = 1'b1;
        repeat (2) @(negedge clk);
        vblk = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic wait_acks(input int base, input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (ack_cnt - base >= n) ok = 1'b1;
        end
    endtask

    // Source responder: ack two cycles after SRC_RD, or spurious acks on demand.
    initial begin
        src_ack = 1'b0;
        src_d   = 8'h00;
        forever begin
            @(negedge clk);
            if (spur_on) begin
                src_ack = 1'b1;
                src_d   = 8'hFF;
            end else if (src_ack) begin
                src_ack = 1'b0;
            end else if (src_rd) begin
                @(negedge clk);
                src_d   = src_mem[src_a];
                src_ack = 1'b1;
                ack_cnt++;
            end
        end
    end

    initial begin
        int  base;
        bit  seen;
        bit  rd_seen;
        bit  busy_seen;

        rst     = 1'b1;
        vblk    = 1'b0;
        copy_en = 1'b0;
        spra_a  = 7'd0;
        for (int k = 0; k < 512; k++) src_mem[k] = 8'h00;
        for (int k = 0; k < 128; k++) model_tab[k] = 24'h0;

        repeat (3) @(negedge clk);
        check_eq("rst_src_a", 32'(src_a), 32'h0);
        check_eq("rst_src_rd", 32'(src_rd), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_overrun", 32'(overrun), 32'h0);
        check_eq("rst_spra_d", 32'(spra_d), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full copy of frame A.
        fill_src(0);
        spra_a = 7'h05;
        base = ack_cnt;
        pulse_vblk(1'b1);
        check_eq("a_busy", 32'(busy), 32'h1);
        wait_done(3000, seen);
        check_eq("a_done_seen", 32'(seen), 32'h1);
        check_eq("a_acks", 32'(ack_cnt - base), 32'd384);
        check_eq("a_busy_at_done", 32'(busy), 32'h0);
        @(negedge clk);
        check_eq("a_done_pulse", 32'(done), 32'h0);
        check_eq("a_entry5", 32'(spra_d), 32'h854505);
        check_eq("a_overrun", 32'(overrun), 32'h0);
        model_copy(0, 384);
        check_table("tab_a");

        // VBLK rise with copying disabled.
        fill_src(1);
        pulse_vblk(1'b0);
        rd_seen   = 1'b0;
        busy_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            rd_seen   |= src_rd;
            busy_seen |= busy;
        end
        check_eq("noen_rd", 32'(rd_seen), 32'h0);
        check_eq("noen_busy", 32'(busy_seen), 32'h0);
        check_table("tab_noen");

        // Second VBLK rise part way through a copy of frame B.
        spra_a = 7'h05;
        base = ack_cnt;
        pulse_vblk(1'b1);
        wait_acks(base, 100, 3000, seen);
        check_eq("ovr_ack100", 32'(seen), 32'h1);
        check_eq("ovr_busy", 32'(busy), 32'h1);
`ifdef SPRITE_SHADOW_DBUF_EN
        check_table("tab_during");
        spra_a = 7'h05;
`endif
        pulse_vblk(1'b1);
        wait_done(3000, seen);
        check_eq("ovr_done_seen", 32'(seen), 32'h1);
        check_eq("ovr_acks", 32'(ack_cnt - base), 32'd384);
`ifdef SPRITE_SHADOW_DBUF_EN
        check_eq("ovr_old_at_done", 32'(spra_d), 32'h854505);
`endif
        @(negedge clk);
        check_eq("ovr_entry5", 32'(spra_d), 32'hB97939);
        check_eq("ovr_overrun", 32'(overrun), 32'h1);
        model_copy(1, 384);
        check_table("tab_b");
        repeat (50) @(negedge clk);
        check_eq("ovr_sticky", 32'(overrun), 32'h1);

        // RESET after the 200th ack of a copy of frame A.
        fill_src(0);
        base = ack_cnt;
        pulse_vblk(1'b1);
        wait_acks(base, 200, 3000, seen);
        check_eq("abort_ack200", 32'(seen), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort_src_rd", 32'(src_rd), 32'h0);
        check_eq("abort_busy", 32'(busy), 32'h0);
        check_eq("abort_overrun", 32'(overrun), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        spra_a = 7'h05;
        @(negedge clk);
`ifdef SPRITE_SHADOW_DBUF_EN
        check_eq("abort_entry5", 32'(spra_d), 32'hB97939);
`else
        check_eq("abort_entry5", 32'(spra_d), 32'hB94505);
        model_copy(0, 200);
`endif
        check_table("tab_abort");

        // Spurious acknowledges while idle must not write.
        spur_on = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("spur_busy", 32'(busy), 32'h0);
        check_eq("spur_src_rd", 32'(src_rd), 32'h0);
        spur_on = 1'b0;
        repeat (2) @(negedge clk);
        check_table("tab_spur");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sprite_attr_shadow.md
Name: sprite_attr_shadow

Overview:
- Upstream feeder of the sprite line renderer: owns the 128 x 24-bit attribute table that the renderer scans through SPRA_A/SPRA_D.
- At each vertical-blank start, copies the three CPU sprite-RAM byte banks into the shadow table through a request/acknowledge read port.
- The renderer therefore sees a frame-stable snapshot, immune to mid-frame CPU writes.

Parameters:
- NENT, 128, shadow entries (64 sprites x 2 words); power of two.
- NBANK, 3, source byte banks; bank b fills SPRA_D[8b+7:8b].
- SRC_AW, 9, source address width = {bank[1:0], idx[6:0]}.

Ports:
- VCLKx4  in  1  sole clock, all logic on posedge.
- RESET  in  1  asynchronous, active-high.
- VBLK  in  1  vertical blank level from video timing; same clock domain.
- COPY_EN  in  1  copy permitted; sampled at VBLK rising edge.
- SRC_A  out  9  source address {bank, idx}.
- SRC_RD  out  1  read request; held until acknowledged.
- SRC_ACK  in  1  one-cycle acknowledge; SRC_D valid this cycle.
- SRC_D  in  8  source byte.
- SPRA_A  in  7  renderer read address.
- SPRA_D  out  24  attribute word, {bank2, bank1, bank0}.
- BUSY  out  1  copy in progress.
- DONE  out  1  one-cycle pulse on copy completion.
- OVERRUN  out  1  sticky: VBLK edge arrived while BUSY.

Behaviour:
- Reset values: SRC_A=0, SRC_RD=0, BUSY=0, DONE=0, OVERRUN=0, SPRA_D=0, state IDLE, counter 0. Shadow RAM contents are not cleared.
- Edge detect: one register on VBLK; rise = VBLK & ~vblk_q.
- Counter cnt[8:0]: cnt[8:7] is the bank (0..2), cnt[6:0] is the index. SRC_A=cnt. Order: all 128 bytes of bank 0, then bank 1, then bank 2.
- FSM:
  - IDLE: on rise & COPY_EN, go to REQ with cnt=0 and BUSY=1. On rise & ~COPY_EN, stay in IDLE.
  - REQ: assert SRC_RD and go to WAIT.
  - WAIT: SRC_RD stays high. On SRC_ACK, write SRC_D into shadow entry cnt[6:0] under byte lane cnt[8:7].
    - If cnt == {2'd2, 7'h7F}: go to FIN and drop SRC_RD.
    - Otherwise cnt+1, drop SRC_RD for one cycle, return to REQ.
  - FIN: DONE=1 for one cycle, BUSY=0, go to IDLE.
- Handshake: SRC_A is stable whenever SRC_RD=1. SRC_ACK seen while not in WAIT is ignored. There is no timeout.
- Minimum copy time: 768 cycles plus ack latency.
- Rise while BUSY: the copy continues unchanged and OVERRUN sets. OVERRUN clears only on RESET.
- RESET mid-copy: abort immediately, SRC_RD=0, partially written shadow remains.
- Read port:
  - SPRA_D is registered, so data for SPRA_A appears 1 cycle later. The renderer holds the address ≥2 VCLKx4 cycles.
  - Read and write to the same entry in the same cycle returns old data (read-before-write).
- Lane 3 does not exist; cnt[8:7]==3 is unreachable.

Optional Feature:
- Macro SPRITE_SHADOW_DBUF_EN.
- Defined:
  - Two shadow pages. The copy writes the back page while SPRA_D reads the front page.
  - The page select toggles on the cycle DONE pulses, and the first read after the toggle returns the new page.
  - An aborted copy never swaps.
- Undefined:
  - Single page; writes land directly in the displayed table.
  - A copy stretching past VBLK fall may tear. The bench flags this as legal, not an error.

Decomposition:
- Package sprite_shadow_pkg holds:
  - FSM state enum: IDLE, REQ, WAIT, FIN.
  - Constants NENT=128, LAST_CNT=9'h17F, LANE_W=8.
- Sub-module sprite_shadow_dpram: 128 x 24 simple dual-port RAM with 3 byte-enables, registered read port, and an optional page bit in the address when DBUF is enabled.

Test Plan:
- Fill source bank b, idx i with byte (b<<6)^i; pulse VBLK with COPY_EN=1 and SRC_ACK 2 cycles after each SRC_RD. Response: DONE after 384 acks; SPRA_A=7'h05 gives SPRA_D=24'h854505 one cycle later.
- COPY_EN=0 at VBLK rise: SRC_RD never asserts, BUSY stays 0, SPRA_D unchanged.
- Second VBLK rise at ack #100 of a copy: copy ends normally after 384 acks, OVERRUN=1 and stays 1.
- RESET asserted at ack #200: SRC_RD=0 and BUSY=0 immediately. Entries already written hold the new data; later entries hold the old data.
- Spurious SRC_ACK in IDLE with SRC_D=8'hFF: no shadow write occurs, verified by reading all 128 entries.
- SPRITE_SHADOW_DBUF_EN build: during a copy, SPRA_D returns the old table for all entries. The cycle after DONE, it returns the new table. After a RESET abort, it still returns the old table.
